// File: rtl/gtxe2_chnl_rx_des.sv
// gtxe2_chnl_rx_des: LSB-first serial-to-parallel deserializer with K28.5 alignment.
// Define GTXE2_CHNL_RX_DES_ALIGN_EN to enable the comma-alignment state machine.

module gtxe2_chnl_rx_des #(
    parameter int         width    = 20,
    parameter logic [9:0] comma_p  = 10'b0101111100,
    parameter logic [9:0] comma_n  = 10'b1010000011,
    parameter int         miss_max = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             indata,
    input  logic             idle_in,
    output logic [width-1:0] outdata,
    output logic             outvalid,
    output logic             idle_out,
    output logic             comma_out,
    output logic             aligned,
    output logic             realign
);

    localparam int            CW   = $clog2(width);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    if (!(width == 20 || width == 40)) begin : g_bad_width
        $error("gtxe2_chnl_rx_des: width must be 20 or 40");
    end
    if (miss_max < 1 || miss_max > 7) begin : g_bad_miss
        $error("gtxe2_chnl_rx_des: miss_max must be 1..7");
    end

    logic [width-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_ia;
    logic [width-1:0] r_outdata;
    logic             r_outvalid;
    logic             r_idle_out;
    logic             r_comma_out;
    logic             r_aligned;

    logic             w_b;
    logic [width-1:0] w_sr_nxt;
    logic             w_cap;
    logic [CW-1:0]    w_cnt_inc;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_do_cap;
    logic             w_cm;

    // Idle bits enter the word as 0 so a dead line never forms a comma.
    assign w_b       = indata & ~idle_in;
    assign w_sr_nxt  = {w_b, r_sr[width-1:1]};
    assign w_cap     = (r_cnt == LAST);
    assign w_cnt_inc = w_cap ? '0 : r_cnt + CW'(1);
    assign w_cm      = (w_sr_nxt[9:0] == comma_p) ||
                       (w_sr_nxt[9:0] == comma_n);

`ifdef GTXE2_CHNL_RX_DES_ALIGN_EN
    typedef enum logic {
        UNALIGNED = 1'b0,
        ALIGNED   = 1'b1
    } state_t;

    localparam logic [CW-1:0] NINE     = CW'(9);
    localparam logic [CW-1:0] TEN      = CW'(10);
    localparam logic [2:0]    MISS_LIM = 3'(miss_max);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_miss;
    logic [2:0] w_miss_nxt;
    logic       r_realign;
    logic [9:0] w_win;
    logic       w_hit;
    logic       w_force;

    // Window holds the newest 10 bits, oldest at bit 0.
    assign w_win = w_sr_nxt[width-1:width-10];
    assign w_hit = ~idle_in & ((w_win == comma_p) || (w_win == comma_n));

    always_comb begin
        w_state_nxt = r_state;
        w_miss_nxt  = r_miss;
        w_force     = 1'b0;
        if (idle_in) begin
            w_state_nxt = UNALIGNED;
            w_miss_nxt  = '0;
        end else if (w_hit) begin
            unique case (r_state)
                UNALIGNED: begin
                    w_force     = 1'b1;
                    w_state_nxt = ALIGNED;
                    w_miss_nxt  = '0;
                end
                ALIGNED: begin
                    if (r_cnt == NINE) begin
                        w_miss_nxt = '0;
                    end else if (r_miss + 3'd1 == MISS_LIM) begin
                        w_state_nxt = UNALIGNED;
                        w_miss_nxt  = '0;
                    end else begin
                        w_miss_nxt = r_miss + 3'd1;
                    end
                end
                default: w_state_nxt = UNALIGNED;
            endcase
        end
    end

    // A forced boundary discards the partial word, even on a capture edge.
    assign w_cnt_nxt = w_force ? TEN : w_cnt_inc;
    assign w_do_cap  = w_cap & ~w_force;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= UNALIGNED;
            r_miss    <= '0;
            r_aligned <= 1'b0;
            r_realign <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_miss    <= w_miss_nxt;
            r_aligned <= (w_state_nxt == ALIGNED);
            r_realign <= w_force & (r_cnt != NINE);
        end
    end

    assign realign = r_realign;
`else
    assign w_cnt_nxt = w_cnt_inc;
    assign w_do_cap  = w_cap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_aligned <= 1'b0;
        end else begin
            r_aligned <= 1'b1;
        end
    end

    assign realign = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sr        <= '0;
            r_cnt       <= '0;
            r_ia        <= 1'b0;
            r_outdata   <= '0;
            r_outvalid  <= 1'b0;
            r_idle_out  <= 1'b0;
            r_comma_out <= 1'b0;
        end else begin
            r_sr       <= w_sr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ia       <= w_do_cap ? 1'b0 : (r_ia | idle_in);
            r_outvalid <= w_do_cap;
            if (w_do_cap) begin
                r_outdata   <= w_sr_nxt;
                r_idle_out  <= r_ia | idle_in;
                r_comma_out <= w_cm;
            end
        end
    end

    assign outdata   = r_outdata;
    assign outvalid  = r_outvalid;
    assign idle_out  = r_idle_out;
    assign comma_out = r_comma_out;
    assign aligned   = r_aligned;

endmodule
